// File: rtl/audio_mixer_n.sv
// rtl/audio_mixer_n.sv - N-channel sequential gain/mute mixer with saturating output; optional peak meter under MIXER_PEAK_EN
module audio_mixer_n #(
  parameter  int NUM_CH   = 4,
  parameter  int SAMPLE_W = 16,
  parameter  int GAIN_W   = 3,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [NUM_CH*SAMPLE_W-1:0] ch_sample,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic                       cmd_we,
  input  logic [CH_W-1:0]            cmd_ch,
  input  logic [GAIN_W-1:0]          cmd_gain,
  input  logic                       cmd_mute,
  output logic [SAMPLE_W-1:0]        out_sample,
  output logic                       out_valid,
  output logic                       out_sat,
  output logic                       busy,
  output logic                       overrun
`ifdef MIXER_PEAK_EN
  ,
  input  logic                       peak_clr,
  output logic [SAMPLE_W-1:0]        peak_level
`endif
);

  localparam int ACC_W  = SAMPLE_W + CH_W;
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} stateT;

  stateT state, stateNext;

  logic [SAMPLE_W-1:0] holdReg [NUM_CH];
  logic [GAIN_W-1:0]   gainReg [NUM_CH];
  logic                muteReg [NUM_CH];

  logic [SAMPLE_W-1:0] snap  [NUM_CH];
  logic [GAIN_W-1:0]   gsnap [NUM_CH];
  logic                msnap [NUM_CH];

  logic [CH_W-1:0]   idx;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  accNext;
  logic [GAIN_W:0]   gainPlus;
  logic [PROD_W-1:0] prod;
  logic [SAMPLE_W:0] term;

  logic startMix;
  logic lastStep;

  assign startMix  = (state == IDLE) && tick;
  assign lastStep  = (state == ACCUM) && (idx == LAST_IDX);
  assign out_valid = (state == DONE);
  assign busy      = (state == ACCUM);

  // Generator hold registers and per-channel gain/mute control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        holdReg[i] <= '0;
        gainReg[i] <= '1;
        muteReg[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i]) begin
          holdReg[i] <= ch_sample[i*SAMPLE_W +: SAMPLE_W];
        end
        // Only in-range channel numbers can match, so out-of-range writes fall through
        if (cmd_we && (cmd_ch == CH_W'(i))) begin
          gainReg[i] <= cmd_gain;
          muteReg[i] <= cmd_mute;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state: one ACCUM cycle per channel, then a single DONE cycle carrying out_valid
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (tick) stateNext = ACCUM;
      ACCUM:   if (idx == LAST_IDX) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Scaled contribution of the channel currently addressed by idx
  always_comb begin
    gainPlus = {1'b0, gsnap[idx]} + (GAIN_W+1)'(1);
    prod     = {{(GAIN_W+1){1'b0}}, snap[idx]} * {{SAMPLE_W{1'b0}}, gainPlus};
    term     = msnap[idx] ? '0 : prod[PROD_W-1:GAIN_W];
    accNext  = acc + ACC_W'(term);
  end

  // Snapshot at tick, sequential accumulation, saturation and overrun detection
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        snap[i]  <= '0;
        gsnap[i] <= '1;
        msnap[i] <= 1'b0;
      end
      acc        <= '0;
      idx        <= '0;
      out_sample <= '0;
      out_sat    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= tick && (state != IDLE);
      if (startMix) begin
        // Same-cycle loads and register writes bypass into the snapshot so the mix is frozen here
        for (int i = 0; i < NUM_CH; i++) begin
          snap[i] <= ch_valid[i] ? ch_sample[i*SAMPLE_W +: SAMPLE_W] : holdReg[i];
          if (cmd_we && (cmd_ch == CH_W'(i))) begin
            gsnap[i] <= cmd_gain;
            msnap[i] <= cmd_mute;
          end else begin
            gsnap[i] <= gainReg[i];
            msnap[i] <= muteReg[i];
          end
        end
        acc <= '0;
        idx <= '0;
      end else if (state == ACCUM) begin
        acc <= accNext;
        idx <= idx + CH_W'(1);
      end
      // The final sum is resolved on the last accumulate step so the result lands in DONE
      if (lastStep) begin
        if (|accNext[ACC_W-1:SAMPLE_W]) begin
          out_sample <= '1;
          out_sat    <= 1'b1;
        end else begin
          out_sample <= accNext[SAMPLE_W-1:0];
          out_sat    <= 1'b0;
        end
      end
    end
  end

`ifdef MIXER_PEAK_EN
  // Peak meter: tracks the largest published sample; a clear coinciding with a result restarts from it
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_level <= '0;
    end else if (peak_clr) begin
      peak_level <= out_valid ? out_sample : '0;
    end else if (out_valid && (out_sample > peak_level)) begin
      peak_level <= out_sample;
    end
  end
`endif

endmodule

// File: tb/tb_audio_mixer_n.sv
// tb/tb_audio_mixer_n.sv - directed self-checking bench for audio_mixer_n (peak meter checks under MIXER_PEAK_EN)
module tb_audio_mixer_n;

  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [63:0] chSample = '0;
  logic [3:0]  chValid = '0;
  logic        cmdWe = 1'b0;
  logic [1:0]  cmdCh = '0;
  logic [2:0]  cmdGain = '0;
  logic        cmdMute = 1'b0;
  logic [15:0] outSample;
  logic        outValid;
  logic        outSat;
  logic        busy;
  logic        overrun;
  logic        peakClr = 1'b0;
  logic [15:0] peakLevel;
  logic        clrAtValid = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [15:0] mSample;
  logic        mSat;
  int          mLat;
  int          mBusy;
  int          nOver;
  int          nValid;

  audio_mixer_n #(
    .NUM_CH(NUM_CH),
    .SAMPLE_W(SAMPLE_W),
    .GAIN_W(GAIN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .ch_sample(chSample),
    .ch_valid(chValid),
    .cmd_we(cmdWe),
    .cmd_ch(cmdCh),
    .cmd_gain(cmdGain),
    .cmd_mute(cmdMute),
    .out_sample(outSample),
    .out_valid(outValid),
    .out_sat(outSat),
    .busy(busy),
    .overrun(overrun)
`ifdef MIXER_PEAK_EN
    ,
    .peak_clr(peakClr),
    .peak_level(peakLevel)
`endif
  );

`ifndef MIXER_PEAK_EN
  assign peakLevel = '0;
`endif

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic loadCh(input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] a2, input logic [15:0] a3);
    chSample = {a3, a2, a1, a0};
    chValid  = 4'hF;
    step();
    chValid  = 4'h0;
  endtask

  task automatic writeCmd(input logic [1:0] ch, input logic [2:0] g, input logic m);
    cmdWe = 1'b1; cmdCh = ch; cmdGain = g; cmdMute = m;
    step();
    cmdWe = 1'b0;
  endtask

  // Pulses tick (with whatever loads/writes the caller staged), waits for out_valid with a bound
  task automatic doMix(output logic [15:0] s, output logic sat, output int lat, output int busyCnt);
    tick = 1'b1;
    step();
    tick = 1'b0; chValid = 4'h0; cmdWe = 1'b0;
    lat = 1; busyCnt = 0;
    while (!outValid && lat < 20) begin
      if (busy) busyCnt++;
      step();
      lat++;
    end
    s = outSample;
    sat = outSat;
    if (clrAtValid) peakClr = 1'b1;
    step();
    peakClr = 1'b0;
  endtask

  // Ticks in cycle 0 and cycle t2, then counts overrun pulses and results over 16 cycles
  task automatic tickPattern(input int t2, output int ov, output int vl);
    ov = 0; vl = 0;
    for (int c = 0; c < 16; c++) begin
      tick = (c == 0 || c == t2);
      step();
      if (overrun) ov++;
      if (outValid) vl++;
    end
    tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step(); step();
    checkVal("rst_out_sample", outSample, 16'h0);
    checkVal("rst_out_valid", outValid, 1'b0);
    checkVal("rst_out_sat", outSat, 1'b0);
    checkVal("rst_busy", busy, 1'b0);
    checkVal("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    step();

    // 1: all-zero mix, latency and busy window
    doMix(mSample, mSat, mLat, mBusy);
    checkVal("t1_latency", mLat, 5);
    checkVal("t1_busy_cycles", mBusy, 4);
    checkVal("t1_sample", mSample, 16'h0000);
    checkVal("t1_sat", mSat, 1'b0);

    // 2: plain sum at unity gain
    loadCh(16'd1000, 16'd2000, 16'd3000, 16'd4000);
    doMix(mSample, mSat, mLat, mBusy);
    checkVal("t2_latency", mLat, 5);
    checkVal("t2_sample", mSample, 16'h2710);
    checkVal("t2_sat", mSat, 1'b0);

    // 3: 4 x 0x8000 = 0x20000 clips
    loadCh(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    doMix(mSample, mSat, mLat, mBusy);
    checkVal("t3_latency", mLat, 5);
    checkVal("t3_sample", mSample, 16'hFFFF);
    checkVal("t3_sat", mSat, 1'b1);

    // 4: gain[0]=3 and channel data bypassed at tick, channel 1 muted beforehand
    loadCh(16'h0, 16'h0, 16'h0, 16'h0);
    writeCmd(2'd1, 3'd7, 1'b1);
    chSample = {16'h0, 16'h0, 16'h4000, 16'h1000};
    chValid  = 4'b0011;
    cmdWe = 1'b1; cmdCh = 2'd0; cmdGain = 3'd3; cmdMute = 1'b0;
    doMix(mSample, mSat, mLat, mBusy);
    checkVal("t4_sample", mSample, 16'h0800);
    checkVal("t4_sat", mSat, 1'b0);

    // 4b: minimum gain with truncation: 7*4>>3=3, 19*1>>3=2, muted 0xFFFF ignored
    writeCmd(2'd2, 3'd0, 1'b0);
    loadCh(16'h0007, 16'hFFFF, 16'h0013, 16'h0000);
    doMix(mSample, mSat, mLat, mBusy);
    checkVal("t4b_sample", mSample, 16'h0005);
    checkVal("t4b_sat", mSat, 1'b0);

    // 5: overrun during ACCUM, in DONE, and first accepted tick after DONE
    rst = 1'b1; step(); rst = 1'b0;
    loadCh(16'd1, 16'd2, 16'd3, 16'd4);
    tickPattern(2, nOver, nValid);
    checkVal("t5_accum_overrun", nOver, 1);
    checkVal("t5_accum_valids", nValid, 1);
    checkVal("t5_accum_sample", outSample, 16'd10);
    tickPattern(5, nOver, nValid);
    checkVal("t5_done_overrun", nOver, 1);
    checkVal("t5_done_valids", nValid, 1);
    tickPattern(6, nOver, nValid);
    checkVal("t5_next_overrun", nOver, 0);
    checkVal("t5_next_valids", nValid, 2);

    // 5b: reset in the 3rd ACCUM cycle aborts the mix
    tick = 1'b1; step(); tick = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    checkVal("t5_rst_out_sample", outSample, 16'h0);
    checkVal("t5_rst_out_valid", outValid, 1'b0);
    checkVal("t5_rst_out_sat", outSat, 1'b0);
    checkVal("t5_rst_busy", busy, 1'b0);
    checkVal("t5_rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    nValid = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (outValid) nValid++;
    end
    checkVal("t5_rst_no_valid", nValid, 0);
    doMix(mSample, mSat, mLat, mBusy);
    checkVal("t5_rst_holds_cleared", mSample, 16'h0);
    loadCh(16'd1000, 16'd0, 16'd0, 16'd0);
    doMix(mSample, mSat, mLat, mBusy);
    checkVal("t5_rst_gain_unity", mSample, 16'd1000);

`ifdef MIXER_PEAK_EN
    // 6: peak meter
    rst = 1'b1; step(); rst = 1'b0;
    checkVal("t6_peak_rst", peakLevel, 16'h0);
    loadCh(16'h1000, 16'h0, 16'h0, 16'h0);
    doMix(mSample, mSat, mLat, mBusy);
    checkVal("t6_peak_1000", peakLevel, 16'h1000);
    loadCh(16'h3000, 16'h0, 16'h0, 16'h0);
    doMix(mSample, mSat, mLat, mBusy);
    checkVal("t6_peak_3000", peakLevel, 16'h3000);
    loadCh(16'h2000, 16'h0, 16'h0, 16'h0);
    doMix(mSample, mSat, mLat, mBusy);
    checkVal("t6_peak_hold", peakLevel, 16'h3000);
    peakClr = 1'b1; step(); peakClr = 1'b0;
    checkVal("t6_peak_clr", peakLevel, 16'h0);
    loadCh(16'h0500, 16'h0, 16'h0, 16'h0);
    clrAtValid = 1'b1;
    doMix(mSample, mSat, mLat, mBusy);
    clrAtValid = 1'b0;
    checkVal("t6_peak_clr_with_valid", peakLevel, 16'h0500);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
